// File: rtl/qsn_layer_sched_85b.sv
// qsn_layer_sched_85b: per-layer column issue sequencer for the shared QSN.
// Walks table entries, drives shift/mux selects and re-aligns column tags.
module qsn_layer_sched_85b #(
  parameter int CHECK_PARALLELISM = 85,
  parameter int LAYER_NUM         = 4,
  parameter int COL_NUM           = 8,
  parameter int PIPE_LAT          = 3,
  parameter int SHIFT_W           = $clog2(CHECK_PARALLELISM-1),
  parameter int ADDR_W            = $clog2(LAYER_NUM*COL_NUM),
  parameter int LAYER_W           = $clog2(LAYER_NUM),
  parameter int COL_W             = $clog2(COL_NUM)
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               tbl_wr_en,
  input  logic [ADDR_W-1:0]  tbl_wr_addr,
  input  logic [SHIFT_W+1:0] tbl_wr_data,
  output logic               tbl_wr_drop,
  input  logic               start,
  input  logic [LAYER_W-1:0] layer_id,
  input  logic               issue_stall,
  output logic               busy,
  output logic               in_rd_en,
  output logic [COL_W-1:0]   col_idx,
  output logic [SHIFT_W-1:0] shift_factor,
  output logic               sw_in_src,
  output logic [2:0]         sw_in_bit0_src,
  output logic               out_valid,
  output logic [COL_W-1:0]   out_col_idx,
  output logic               done
);

  localparam int ENTRIES = LAYER_NUM * COL_NUM;
  localparam int CNT_W   = $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  state_t             state;
  logic [SHIFT_W+1:0] tbl [ENTRIES];
  logic [LAYER_W-1:0] layer_q;
  logic [COL_W-1:0]   col;
  logic [CNT_W-1:0]   cnt;
  logic [COL_W:0]     dly [PIPE_LAT];

  logic               addr_ok;
  logic               layer_ok;
  logic [ADDR_W-1:0]  rd_addr;
  logic [SHIFT_W+1:0] ent;
  logic [SHIFT_W-1:0] ent_shift;
  logic [SHIFT_W-1:0] red_shift;
  logic [1:0]         ent_src;
  logic               sel_sw;
  logic [2:0]         sel_b0;

  if (ENTRIES < (1 << ADDR_W)) begin : g_addr_chk
    assign addr_ok = 32'(tbl_wr_addr) < ENTRIES;
  end else begin : g_addr_all
    assign addr_ok = 1'b1;
  end

  if (LAYER_NUM < (1 << LAYER_W)) begin : g_layer_chk
    assign layer_ok = 32'(layer_id) < LAYER_NUM;
  end else begin : g_layer_all
    assign layer_ok = 1'b1;
  end

  assign rd_addr   = ADDR_W'(32'(layer_q) * COL_NUM + 32'(col));
  assign ent       = tbl[rd_addr];
  assign ent_shift = ent[SHIFT_W-1:0];
  assign ent_src   = ent[SHIFT_W+1:SHIFT_W];

  // Table may hold shifts up to 2^SHIFT_W-1; one subtraction suffices.
  assign red_shift =
    (ent_shift >= SHIFT_W'(CHECK_PARALLELISM)) ?
    ent_shift - SHIFT_W'(CHECK_PARALLELISM) :
    ent_shift;

  always_comb begin
    sel_sw = 1'b0;
    sel_b0 = 3'b001;
    unique case (1'b1)
      ent_src == 2'd1: begin
        sel_sw = 1'b1;
        sel_b0 = 3'b010;
      end
      ent_src == 2'd2: begin
        sel_sw = 1'b1;
        sel_b0 = 3'b100;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      in_rd_en       <= 1'b0;
      col_idx        <= '0;
      shift_factor   <= '0;
      sw_in_src      <= 1'b0;
      sw_in_bit0_src <= 3'b000;
      layer_q        <= '0;
      col            <= '0;
      cnt            <= '0;
      tbl_wr_drop    <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= '0;
    end else begin
      tbl_wr_drop <= tbl_wr_en && (state != IDLE || !addr_ok);
      if (tbl_wr_en && state == IDLE && addr_ok)
        tbl[tbl_wr_addr] <= tbl_wr_data;
      in_rd_en <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && layer_ok) begin
            state   <= ISSUE;
            busy    <= 1'b1;
            layer_q <= layer_id;
            col     <= '0;
          end
        end
        ISSUE: begin
          if (!issue_stall) begin
            in_rd_en       <= 1'b1;
            col_idx        <= col;
            shift_factor   <= red_shift;
            sw_in_src      <= sel_sw;
            sw_in_bit0_src <= sel_b0;
            col            <= col + COL_W'(1);
            if (col == COL_W'(COL_NUM - 1)) begin
              state <= DRAIN;
              cnt   <= '0;
            end
          end
        end
        DRAIN: begin
          // done lands with the last tag leaving the delay line
          if (done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt == CNT_W'(PIPE_LAT - 1)) begin
            done <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) dly[i] <= '0;
    end else begin
      dly[0] <= {in_rd_en, col_idx};
      for (int i = 1; i < PIPE_LAT; i++) dly[i] <= dly[i-1];
    end
  end

  assign out_valid   = dly[PIPE_LAT-1][COL_W];
  assign out_col_idx = dly[PIPE_LAT-1][COL_W-1:0];

endmodule

// File: tb/tb_qsn_layer_sched_85b.sv
// tb_qsn_layer_sched_85b: scoreboard bench for the layer issue sequencer.
// Directed table loads and sweeps; a monitor pops expected issues/outputs.
module tb_qsn_layer_sched_85b;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       tbl_wr_en = 1'b0;
  logic [4:0] tbl_wr_addr = '0;
  logic [8:0] tbl_wr_data = '0;
  logic       tbl_wr_drop;
  logic       start = 1'b0;
  logic [1:0] layer_id = '0;
  logic       issue_stall = 1'b0;
  logic       busy;
  logic       in_rd_en;
  logic [2:0] col_idx;
  logic [6:0] shift_factor;
  logic       sw_in_src;
  logic [2:0] sw_in_bit0_src;
  logic       out_valid;
  logic [2:0] out_col_idx;
  logic       done;

  qsn_layer_sched_85b dut (
    .sys_clk        (sys_clk),
    .rst            (rst),
    .tbl_wr_en      (tbl_wr_en),
    .tbl_wr_addr    (tbl_wr_addr),
    .tbl_wr_data    (tbl_wr_data),
    .tbl_wr_drop    (tbl_wr_drop),
    .start          (start),
    .layer_id       (layer_id),
    .issue_stall    (issue_stall),
    .busy           (busy),
    .in_rd_en       (in_rd_en),
    .col_idx        (col_idx),
    .shift_factor   (shift_factor),
    .sw_in_src      (sw_in_src),
    .sw_in_bit0_src (sw_in_bit0_src),
    .out_valid      (out_valid),
    .out_col_idx    (out_col_idx),
    .done           (done)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct { int sh; int sw; int b0; } ent_t;
  typedef struct { int col; int sh; int sw; int b0; } iss_t;
  typedef struct { int col; int last; } out_t;

  ent_t exp_tbl [32];
  iss_t iss_q [$];
  out_t out_q [$];
  int   cyc_q [$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  iss_t m_i;
  out_t m_o;
  int   m_c;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) exp_tbl[i] = '{0, 0, 1};
  endtask

  task automatic load(input int a, input int src, input int sh,
                      input int e_sh, input int e_sw, input int e_b0);
    tbl_wr_en   = 1'b1;
    tbl_wr_addr = 5'(a);
    tbl_wr_data = {2'(src), 7'(sh)};
    tick();
    tbl_wr_en = 1'b0;
    exp_tbl[a] = '{e_sh, e_sw, e_b0};
    chk("wr_drop_idle", tbl_wr_drop, 0);
  endtask

  task automatic push_exp(input int L);
    for (int c = 0; c < 8; c++) begin
      iss_q.push_back('{c, exp_tbl[L*8+c].sh,
                        exp_tbl[L*8+c].sw, exp_tbl[L*8+c].b0});
      out_q.push_back('{c, (c == 7) ? 1 : 0});
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rd"}, in_rd_en, 0);
    chk({tag, "_col"}, col_idx, 0);
    chk({tag, "_sh"}, shift_factor, 0);
    chk({tag, "_sw"}, sw_in_src, 0);
    chk({tag, "_b0"}, sw_in_bit0_src, 0);
    chk({tag, "_ov"}, out_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_drop"}, tbl_wr_drop, 0);
  endtask

  task automatic run(input int L, input int stall_at,
                     input int stall_n, input bit poke);
    int   k;
    bit   got;
    ent_t hold;
    push_exp(L);
    layer_id = 2'(L);
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    got = 1'b0;
    hold = exp_tbl[L*8 + stall_at - 1];
    while (k < 60 && !got) begin
      issue_stall = (k >= stall_at && k < stall_at + stall_n);
      if (poke && k == 1) begin
        start       = 1'b1;
        layer_id    = 2'd3;
        tbl_wr_en   = 1'b1;
        tbl_wr_addr = 5'd5;
        tbl_wr_data = 9'h1FF;
      end else begin
        start     = 1'b0;
        layer_id  = 2'(L);
        tbl_wr_en = 1'b0;
      end
      tick();
      k++;
      if (poke && k == 2) chk("drop_busy", tbl_wr_drop, 1);
      if (poke && k == 3) chk("drop_pulse", tbl_wr_drop, 0);
      if (k > stall_at && k <= stall_at + stall_n) begin
        chk("stall_rd", in_rd_en, 0);
        chk("stall_col", col_idx, stall_at - 1);
        chk("stall_sh", shift_factor, hold.sh);
        chk("stall_sw", sw_in_src, hold.sw);
        chk("stall_b0", sw_in_bit0_src, hold.b0);
      end
      got = done;
    end
    issue_stall = 1'b0;
    start = 1'b0;
    tbl_wr_en = 1'b0;
    if (!got) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("done_lat", k, 11 + stall_n);
      chk("busy_in_done", busy, 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_fall", busy, 0);
      chk("done_pulse", done, 0);
      tick();
      chk("start_in_done_ignored", busy, 0);
    end
  endtask

  always @(negedge sys_clk) begin
    if (!rst) begin
      if (in_rd_en) begin
        if (iss_q.size() == 0) begin
          chk("iss_unexpected", 1, 0);
        end else begin
          m_i = iss_q.pop_front();
          chk("iss_col", col_idx, m_i.col);
          chk("iss_shift", shift_factor, m_i.sh);
          chk("iss_sw", sw_in_src, m_i.sw);
          chk("iss_b0", sw_in_bit0_src, m_i.b0);
        end
        cyc_q.push_back(cyc);
      end
      if (out_valid) begin
        if (out_q.size() == 0) begin
          chk("out_unexpected", 1, 0);
        end else begin
          m_o = out_q.pop_front();
          chk("out_col", out_col_idx, m_o.col);
          chk("out_done", done, m_o.last);
        end
        if (cyc_q.size() != 0) begin
          m_c = cyc_q.pop_front();
          chk("out_lat", cyc - m_c, 3);
        end
      end else if (done) begin
        chk("done_stray", 1, 0);
      end
    end
  end

  initial begin
    clear_model();
    rst = 1'b1;
    tick();
    tick();
    chk_zero("rst");
    rst = 1'b0;
    tick();

    for (int c = 0; c < 8; c++) load(8 + c, 0, c, c, 0, 1);
    load(16, 0, 100, 15, 0, 1);
    load(17, 1, 84,  84, 1, 2);
    load(18, 2, 85,  0,  1, 4);
    load(19, 3, 127, 42, 0, 1);
    load(20, 1, 5,   5,  1, 2);
    load(21, 2, 0,   0,  1, 4);
    load(22, 3, 42,  42, 0, 1);
    load(23, 0, 86,  1,  0, 1);
    load(5,  1, 3,   3,  1, 2);

    run(1, 3, 0, 1'b0);
    run(2, 3, 2, 1'b1);
    run(0, 3, 0, 1'b0);

    // abort a layer-1 sweep right after column 4 issues
    push_exp(1);
    layer_id = 2'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("pre_rst_col", col_idx, 4);
    chk("pre_rst_rd", in_rd_en, 1);
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    iss_q.delete();
    out_q.delete();
    cyc_q.delete();
    clear_model();
    tick();
    rst = 1'b0;
    repeat (8) tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ov", out_valid, 0);
    run(1, 3, 0, 1'b0);

    repeat (2) tick();
    chk("iss_q_empty", iss_q.size(), 0);
    chk("out_q_empty", out_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
